// File: rtl/rr_sched_pkg.sv
// Shared types and width helpers for the round-robin resource scheduler.
package rr_sched_pkg;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   // max(1, clog2(n)) so single-entry cases still get a 1-bit field
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate-and-pick: first set request at or above ptr, wrapping.
module rr_priority_pick
   import rr_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = width_of(N_REQ)
)(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] pick,
   output logic [ID_W-1:0]  pick_id,
   output logic             any
);

   int idx;

   always_comb begin
      pick    = '0;
      pick_id = '0;
      any     = 1'b0;
      idx     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(ptr) + i) % N_REQ;
         if (!any && req[idx]) begin
            any       = 1'b1;
            pick[idx] = 1'b1;
            pick_id   = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/rr_resource_scheduler.sv
// Round-robin owner of a shared multi-cycle resource; a grant lasts until
// done, owner withdrawal, or hold timeout.
module rr_resource_scheduler
   import rr_sched_pkg::*;
#(
   parameter int    N_REQ   = 4,
   parameter int    TIMEOUT = 16,
   localparam int   ID_W    = width_of(N_REQ),
   localparam int   CNT_W   = width_of(TIMEOUT + 1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             grant_valid,
   output logic             busy,
   output logic             timeout_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_e           state, state_d;
   logic [N_REQ-1:0] pick, grant_d;
   logic [ID_W-1:0]  pick_id, grant_id_d, ptr, ptr_d, next_ptr;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             any, grant_valid_d, timeout_err_d;
   logic             owner_req, expire, release_now;

   rr_priority_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .req     (req),
      .ptr     (ptr),
      .pick    (pick),
      .pick_id (pick_id),
      .any     (any)
   );

   assign owner_req   = |(req & grant);
   assign expire      = (TIMEOUT != 0) && (cnt == CNT_MAX);
   assign release_now = done || !owner_req || expire;
   assign next_ptr    = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
   assign busy        = (state == BUSY);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= '0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
         timeout_err <= 1'b0;
         ptr         <= '0;
         cnt         <= '0;
      end else begin
         state       <= state_d;
         grant       <= grant_d;
         grant_id    <= grant_id_d;
         grant_valid <= grant_valid_d;
         timeout_err <= timeout_err_d;
         ptr         <= ptr_d;
         cnt         <= cnt_d;
      end
   end

   always_comb begin
      state_d = state;
      if (state == IDLE) begin
         if (any) state_d = BUSY;
      end else begin
         if (release_now) state_d = IDLE;
      end
   end

   always_comb begin
      grant_d       = grant;
      grant_id_d    = grant_id;
      grant_valid_d = grant_valid;
      ptr_d         = ptr;
      cnt_d         = cnt;
      timeout_err_d = 1'b0;
      if (state == IDLE) begin
         if (any) begin
            grant_d       = pick;
            grant_id_d    = pick_id;
            grant_valid_d = 1'b1;
            cnt_d         = '0;
         end
      end else if (release_now) begin
         grant_d       = '0;
         grant_valid_d = 1'b0;
         ptr_d         = next_ptr;
         cnt_d         = '0;
         // error only when the timer alone forced the release
         timeout_err_d = expire && !done && owner_req;
      end else if (TIMEOUT != 0) begin
         cnt_d = cnt + 1'b1;
      end
   end

endmodule
